jtag_idcode_reader: RTL and testbench

Host-side JTAG master that reads a target's 32-bit IDCODE. It drives TCK/TMS/TDI and reads TDO, i.e. the far end of the device-side ID register shift chain. On a start pulse it walks the TAP through Test-Logic-Reset, which selects the IDCODE instruction, then through Shift-DR. It shifts the ID out, returns the TAP to Run-Test/Idle and presents the captured code with a validity flag.

---
 rtl/jtag_idcode_reader.sv | 137 +++++++++++++
 tb/tb_jtag_idcode_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_idcode_reader.sv
// Host-side JTAG master: resets the TAP, which selects IDCODE, then shifts the ID register out of TDO.
// TMS/TDI move only on TCK falling edges. TDO is sampled on TCK rising edges.
module jtag_idcode_reader #(
    parameter int ID_WIDTH = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                TDO,
    output logic                TCK,
    output logic                TMS,
    output logic                TDI,
    output logic                busy,
    output logic                done,
    output logic [ID_WIDTH-1:0] ID_code,
    output logic                ID_valid
);
    localparam int MAXCNT = (ID_WIDTH > 5) ? ID_WIDTH : 5;
    localparam int CNT_W  = $clog2(MAXCNT + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, RESET_WALK, GOTO_SHIFT, SHIFT, EXIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic [ID_WIDTH-1:0] sh_q, sh_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                valid_q, valid_d;

    function automatic logic [CNT_W-1:0] last_period(state_t s);
        case (s)
            RESET_WALK: last_period = CNT_W'(4);
            GOTO_SHIFT: last_period = CNT_W'(3);
            SHIFT:      last_period = CNT_W'(ID_WIDTH - 1);
            default:    last_period = CNT_W'(1);
        endcase
    endfunction

    function automatic state_t next_phase(state_t s);
        case (s)
            RESET_WALK: next_phase = GOTO_SHIFT;
            GOTO_SHIFT: next_phase = SHIFT;
            SHIFT:      next_phase = EXIT;
            EXIT:       next_phase = DONE;
            default:    next_phase = IDLE;
        endcase
    endfunction

    // TMS level for the TCK period identified by (state, period index).
    function automatic logic tms_for(state_t s, logic [CNT_W-1:0] c);
        case (s)
            GOTO_SHIFT: tms_for = (c == CNT_W'(1));
            SHIFT:      tms_for = (c == CNT_W'(ID_WIDTH - 1));
            EXIT:       tms_for = (c == '0);
            default:    tms_for = 1'b1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        sh_d    = sh_q;
        id_d    = id_q;
        valid_d = valid_q;
        case (state_q)
            IDLE, DONE: begin
                tms_d   = 1'b1;
                tck_d   = 1'b0;
                div_d   = '0;
                cnt_d   = '0;
                state_d = start ? RESET_WALK : IDLE;
            end
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        if (state_q == SHIFT) sh_d = {TDO, sh_q[ID_WIDTH-1:1]};
                    end else begin
                        // Falling edge closes a TCK period: advance and present TMS for the next one.
                        if (cnt_q == last_period(state_q)) begin
                            cnt_d   = '0;
                            state_d = next_phase(state_q);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        tms_d = tms_for(state_d, cnt_d);
                        if (state_d == DONE) begin
                            id_d    = sh_q;
                            valid_d = sh_q[0] & ~(&sh_q);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            sh_q    <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            sh_q    <= sh_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign TCK      = tck_q;
    assign TMS      = tms_q;
    assign TDI      = 1'b1;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign ID_code  = id_q;
    assign ID_valid = valid_q;
endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Directed bench for jtag_idcode_reader: behavioural TAP targets on a default and a small instance.
module tb_jtag_idcode_reader;
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7;
    localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1, tdo1, tck1, tms1, tdi1, busy1, done1, valid1;
    logic [31:0] id1;
    logic start2, tdo2, tck2, tms2, tdi2, busy2, done2, valid2;
    logic [7:0] id2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtag_idcode_reader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .TDO(tdo1), .TCK(tck1), .TMS(tms1),
        .TDI(tdi1), .busy(busy1), .done(done1), .ID_code(id1), .ID_valid(valid1)
    );

    jtag_idcode_reader #(.ID_WIDTH(8), .CLK_DIV(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .TDO(tdo2), .TCK(tck2), .TMS(tms2),
        .TDI(tdi2), .busy(busy2), .done(done2), .ID_code(id2), .ID_valid(valid2)
    );

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:     return t ? TLR   : RTI;
            RTI:     return t ? SELDR : RTI;
            SELDR:   return t ? SELIR : CAPDR;
            CAPDR:   return t ? EX1DR : SHDR;
            SHDR:    return t ? EX1DR : SHDR;
            EX1DR:   return t ? UPDR  : PADR;
            PADR:    return t ? EX2DR : PADR;
            EX2DR:   return t ? UPDR  : SHDR;
            UPDR:    return t ? SELDR : RTI;
            SELIR:   return t ? TLR   : CAPIR;
            CAPIR:   return t ? EX1IR : SHIR;
            SHIR:    return t ? EX1IR : SHIR;
            EX1IR:   return t ? UPIR  : PAIR;
            PAIR:    return t ? EX2IR : PAIR;
            EX2IR:   return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    // Target 1: IDCODE 0x4BA00477, TDO optionally forced high or low.
    int          tap1 = SHIR;
    logic [31:0] dr1 = 32'h0;
    logic        tdo_m1 = 1'b1;
    logic [63:0] tms_hist = 64'h0;
    int          rises1 = 0;
    int          tdo_mode = 0;

    always @(posedge tck1) begin
        if (tap1 == CAPDR) dr1 <= 32'h4BA00477;
        else if (tap1 == SHDR) dr1 <= {1'b0, dr1[31:1]};
        tap1     <= tap_next(tap1, tms1);
        tms_hist <= {tms_hist[62:0], tms1};
        rises1   <= rises1 + 1;
    end
    always @(negedge tck1) tdo_m1 <= (tap1 == SHDR) ? dr1[0] : 1'b1;
    assign tdo1 = (tdo_mode == 1) ? 1'b1 : (tdo_mode == 2) ? 1'b0 : tdo_m1;

    // Target 2: 8-bit ID 0xA5.
    int          tap2 = RTI;
    logic [31:0] dr2 = 32'h0;
    logic        tdo_m2 = 1'b1;

    always @(posedge tck2) begin
        if (tap2 == CAPDR) dr2 <= 32'h000000A5;
        else if (tap2 == SHDR) dr2 <= {1'b0, dr2[31:1]};
        tap2 <= tap_next(tap2, tms2);
    end
    always @(negedge tck2) tdo_m2 <= (tap2 == SHDR) ? dr2[0] : 1'b1;
    assign tdo2 = tdo_m2;

    // Edge-discipline monitors: TMS/TDI must not move on a TCK rise; small instance toggles TCK every clk.
    logic tck1_p = 1'b0, tms1_p = 1'b1, tdi1_p = 1'b1;
    logic tck2_p = 1'b0, tms2_p = 1'b1, tdi2_p = 1'b1, busy2_p = 1'b0;
    int   viol1 = 0, viol2 = 0, tog2 = 0;

    always @(negedge clk) begin
        if (tck1 && !tck1_p && (tms1 !== tms1_p || tdi1 !== tdi1_p)) viol1 <= viol1 + 1;
        if (tck2 && !tck2_p && (tms2 !== tms2_p || tdi2 !== tdi2_p)) viol2 <= viol2 + 1;
        if (busy2 && busy2_p && (tck2 === tck2_p)) tog2 <= tog2 + 1;
        tck1_p  <= tck1;
        tms1_p  <= tms1;
        tdi1_p  <= tdi1;
        tck2_p  <= tck2;
        tms2_p  <= tms2;
        tdi2_p  <= tdi2;
        busy2_p <= busy2;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_read1(input bit extra, input bit chain, output int bcyc, output int dcnt);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bcyc = 0;
        dcnt = 0;
        while (busy1 && bcyc < 4000) begin
            bcyc++;
            start1 = extra && (bcyc == 1 || bcyc == 100 || bcyc == 343);
            @(negedge clk);
            if (done1) dcnt++;
        end
        start1 = chain;
        @(negedge clk);
        start1 = 1'b0;
        if (!chain && done1) dcnt++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, dc, r0, n;
        logic [42:0] exp_tms;
        start1 = 1'b0;
        start2 = 1'b0;
        exp_tms = '0;
        for (int k = 0; k < 43; k++)
            exp_tms = {exp_tms[41:0], ((k < 5) || (k == 6) || (k == 40) || (k == 41))};

        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck1), 64'd0);
        check("rst_tms", 64'(tms1), 64'd1);
        check("rst_tdi", 64'(tdi1), 64'd1);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_id", 64'(id1), 64'd0);
        check("rst_valid", 64'(valid1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        r0 = rises1;
        do_read1(1'b0, 1'b0, bc, dc);
        check("nom_busy_cycles", 64'(bc), 64'd344);
        check("nom_done_pulses", 64'(dc), 64'd1);
        check("nom_id", 64'(id1), 64'h4BA00477);
        check("nom_valid", 64'(valid1), 64'd1);
        check("nom_tck_rises", 64'(rises1 - r0), 64'd43);
        check("nom_tms_seq", 64'(tms_hist[42:0]), 64'(exp_tms));
        check("nom_tap_end", 64'(tap1), 64'(RTI));
        check("nom_idle_tms", 64'(tms1), 64'd1);

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (156) @(negedge clk);
        check("mid_hold_id", 64'(id1), 64'h4BA00477);
        check("mid_busy", 64'(busy1), 64'd1);
        check("mid_tck_high", 64'(tck1), 64'd1);
        check("mid_tms_shift", 64'(tms1), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tck", 64'(tck1), 64'd0);
        check("arst_tms", 64'(tms1), 64'd1);
        check("arst_busy", 64'(busy1), 64'd0);
        check("arst_id", 64'(id1), 64'd0);
        check("arst_valid", 64'(valid1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_read1(1'b0, 1'b0, bc, dc);
        check("rec_busy_cycles", 64'(bc), 64'd344);
        check("rec_id", 64'(id1), 64'h4BA00477);
        check("rec_valid", 64'(valid1), 64'd1);
        check("rec_tap_end", 64'(tap1), 64'(RTI));

        tdo_mode = 1;
        do_read1(1'b0, 1'b0, bc, dc);
        check("tdo1_id", 64'(id1), 64'hFFFFFFFF);
        check("tdo1_valid", 64'(valid1), 64'd0);
        tdo_mode = 2;
        do_read1(1'b0, 1'b0, bc, dc);
        check("tdo0_id", 64'(id1), 64'h0);
        check("tdo0_valid", 64'(valid1), 64'd0);
        tdo_mode = 0;

        do_read1(1'b1, 1'b0, bc, dc);
        check("stray_busy_cycles", 64'(bc), 64'd344);
        check("stray_done_pulses", 64'(dc), 64'd1);
        check("stray_id", 64'(id1), 64'h4BA00477);

        do_read1(1'b0, 1'b1, bc, dc);
        check("chain_first_cycles", 64'(bc), 64'd344);
        check("chain_first_done", 64'(dc), 64'd1);
        check("chain_rebusy", 64'(busy1), 64'd1);
        tdo_mode = 1;
        n = 0;
        while (busy1 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        check("chain_second_cycles", 64'(n), 64'd344);
        check("chain_second_done", 64'(done1), 64'd1);
        check("chain_second_id", 64'(id1), 64'hFFFFFFFF);
        tdo_mode = 0;
        @(negedge clk);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (busy2 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("small_busy_cycles", 64'(n), 64'd38);
        check("small_done", 64'(done2), 64'd1);
        check("small_id", 64'(id2), 64'hA5);
        check("small_valid", 64'(valid2), 64'd1);
        @(negedge clk);
        check("small_tap_end", 64'(tap2), 64'(RTI));
        check("small_tck_toggle", 64'(tog2), 64'd0);
        check("small_tms_on_rise", 64'(viol2), 64'd0);
        check("dflt_tms_on_rise", 64'(viol1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
